program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 132 +++++++++++++
 tb/tb_program_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Fetch/execute sequencer: fetches 16-bit words into the instruction register,
// strobes them for one execute cycle and handles LD/ST data handshakes with a bounded wait.
module program_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              halt,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic              imem_ack,
   input  logic [15:0]       imem_data,
   output logic [15:0]       instr,
   output logic              instr_valid,
   output logic              dmem_req,
   input  logic              dmem_ack,
   output logic              busy,
   output logic              err
);

   // Shared instruction-header opcodes (instr[11:8])
   localparam logic [3:0] OP_RST = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_ST  = 4'h3;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_EXEC    = 3'd2;
   localparam logic [2:0] S_MEMWAIT = 3'd3;
   localparam logic [2:0] S_ERROR   = 3'd4;

   localparam int unsigned       WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;

   logic [3:0] opcode;
   logic       is_mem;
   logic       is_rst;
   logic [2:0] done_state;

   assign opcode     = instr_q[11:8];
   assign is_mem     = (opcode == OP_LD) || (opcode == OP_ST);
   assign is_rst     = (opcode == OP_RST);
   assign done_state = (run && !halt) ? S_FETCH : S_IDLE;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      wait_d  = wait_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (run && !halt) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_data;
               state_d = S_EXEC;
            end else begin
               // ack in the final allowed cycle takes priority over the timeout
               wait_d = wait_q + WAIT_W'(1);
               if (wait_q == WAIT_LAST) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         S_EXEC: begin
            wait_d = '0;
            if (is_mem) begin
               state_d = S_MEMWAIT;
            end else begin
               pc_d    = is_rst ? '0 : pc_q + ADDR_W'(1);
               state_d = done_state;
            end
         end
         S_MEMWAIT: begin
            if (dmem_ack) begin
               pc_d    = pc_q + ADDR_W'(1);
               state_d = done_state;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
               if (wait_q == WAIT_LAST) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         S_ERROR: begin
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode straight from the state register so reset drops requests at once
   assign imem_addr   = pc_q;
   assign imem_req    = (state_q == S_FETCH);
   assign dmem_req    = (state_q == S_MEMWAIT);
   assign instr_valid = (state_q == S_EXEC);
   assign instr       = instr_q;
   assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEMWAIT);
   assign err         = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_program_sequencer;

   localparam int AW = 4;
   localparam int MW = 15;
   localparam int NPC = 1 << AW;

   localparam logic [15:0] W_RST = 16'h0100;
   localparam logic [15:0] W_LD  = 16'h0255;
   localparam logic [15:0] W_ST  = 16'h0300;

   localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_DATA = 3, PH_DEAD = 4;

   logic          clk;
   logic          rst;
   logic          run;
   logic          halt;
   logic [AW-1:0] imem_addr;
   logic          imem_req;
   logic          imem_ack = 1'b0;
   logic [15:0]   imem_data = '0;
   logic [15:0]   instr;
   logic          instr_valid;
   logic          dmem_req;
   logic          dmem_ack = 1'b0;
   logic          busy;
   logic          err;

   program_sequencer #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .run(run), .halt(halt),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .busy(busy), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: acks after a programmable number of request cycles
   logic [15:0] prog [16];
   int imem_lat = 0, dmem_lat = 0, fcnt = 0, dcnt = 0;
   bit spur = 0, dspur = 0;

   always @(negedge clk) begin
      imem_data = prog[imem_addr];
      if (imem_req) begin
         imem_ack = (fcnt == imem_lat) || spur;
         fcnt++;
      end else begin
         imem_ack = spur;
         fcnt = 0;
      end
      if (dmem_req) begin
         dmem_ack = (dcnt == dmem_lat);
         dcnt++;
      end else begin
         dmem_ack = dspur;
         dcnt = 0;
      end
   end

   // Behavioural model: instruction-level phases, PC kept as plain integer modulo 2^AW
   int          m_phase, m_pc, m_waited;
   logic [15:0] m_ir;
   bit          m_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase  <= PH_IDLE;
         m_pc     <= 0;
         m_ir     <= '0;
         m_waited <= 0;
         m_err    <= 1'b0;
      end else begin
         case (m_phase)
            PH_IDLE: if (run && !halt) begin
               m_phase  <= PH_FETCH;
               m_waited <= 0;
            end
            PH_FETCH: if (imem_ack) begin
               m_ir    <= imem_data;
               m_phase <= PH_EXEC;
            end else if (m_waited + 1 >= MW) begin
               m_phase <= PH_DEAD;
               m_err   <= 1'b1;
            end else m_waited <= m_waited + 1;
            PH_EXEC: begin
               m_waited <= 0;
               if (m_ir[11:8] == 4'h2 || m_ir[11:8] == 4'h3) m_phase <= PH_DATA;
               else begin
                  m_pc    <= (m_ir[11:8] == 4'h1) ? 0 : (m_pc + 1) % NPC;
                  m_phase <= (run && !halt) ? PH_FETCH : PH_IDLE;
               end
            end
            PH_DATA: if (dmem_ack) begin
               m_pc     <= (m_pc + 1) % NPC;
               m_phase  <= (run && !halt) ? PH_FETCH : PH_IDLE;
               m_waited <= 0;
            end else if (m_waited + 1 >= MW) begin
               m_phase <= PH_DEAD;
               m_err   <= 1'b1;
            end else m_waited <= m_waited + 1;
            default: ;
         endcase
      end
   end

   // Compare process and observation logs
   bit   chk_en = 0;
   int   cyc = 0;
   int   d_cycles = 0;
   logic prev_req = 1'b0;
   int   f_addr[$];
   int   v_addr[$];
   int   v_cyc[$];

   always @(negedge clk) begin
      if (chk_en) begin
         check("imem_req", imem_req, m_phase == PH_FETCH);
         check("imem_addr", imem_addr, m_pc);
         check("instr", instr, m_ir);
         check("instr_valid", instr_valid, m_phase == PH_EXEC);
         check("dmem_req", dmem_req, m_phase == PH_DATA);
         check("busy", busy, m_phase == PH_FETCH || m_phase == PH_EXEC || m_phase == PH_DATA);
         check("err", err, m_err);
      end
      if (instr_valid) begin
         v_addr.push_back(int'(imem_addr));
         v_cyc.push_back(cyc);
      end
      if (imem_req && !prev_req) f_addr.push_back(int'(imem_addr));
      if (dmem_req) d_cycles++;
      prev_req = imem_req;
      cyc++;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      f_addr.delete();
      v_addr.delete();
      v_cyc.delete();
      d_cycles = 0;
   endtask

   task automatic load_nops();
      for (int i = 0; i < 16; i++) prog[i] = {8'h0A, 8'(i)};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      halt = 1'b0;
      cycles(2);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check(name, busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b0;
      halt = 1'b0;
      load_nops();
      @(negedge clk);
      chk_en = 1;
      check("rst_addr", imem_addr, 0);
      check("rst_instr", instr, 16'h0000);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_imem_req", imem_req, 0);
      @(negedge clk);
      rst = 1'b0;
      clear_logs();

      // Three non-memory instructions with zero-wait ack
      run = 1'b1;
      cycles(6);
      run = 1'b0;
      cycles(3);
      check("A_valid_count", v_addr.size(), 3);
      if (v_addr.size() == 3) begin
         check("A_valid_addr0", v_addr[0], 0);
         check("A_valid_addr1", v_addr[1], 1);
         check("A_valid_addr2", v_addr[2], 2);
         check("A_valid_gap01", v_cyc[1] - v_cyc[0], 2);
         check("A_valid_gap12", v_cyc[2] - v_cyc[1], 2);
      end
      check("A_final_pc", imem_addr, 3);
      check("A_idle", busy, 0);

      // LD at address 5 with ack on the third data cycle, spurious acks elsewhere
      do_reset();
      prog[5] = W_LD;
      spur = 1;
      dspur = 1;
      dmem_lat = 2;
      run = 1'b1;
      cycles(22);
      run = 1'b0;
      wait_idle("B_idle");
      check("B_dmem_cycles", d_cycles, 3);
      check("B_fetch_count_ok", f_addr.size() >= 7, 1);
      if (f_addr.size() >= 7) begin
         check("B_fetch5", f_addr[5], 5);
         check("B_fetch6", f_addr[6], 6);
      end
      begin
         int n5 = 0;
         foreach (v_addr[i]) if (v_addr[i] == 5) n5++;
         check("B_single_valid_at5", n5, 1);
      end
      spur = 0;
      dspur = 0;
      dmem_lat = 0;
      prog[5] = {8'h0A, 8'h05};

      // PC wrap from 15 to 0
      do_reset();
      run = 1'b1;
      cycles(34);
      run = 1'b0;
      wait_idle("C1_idle");
      check("C1_fetch_count_ok", f_addr.size() >= 17, 1);
      if (f_addr.size() >= 17) begin
         check("C1_fetch15", f_addr[15], 15);
         check("C1_fetch_wrap", f_addr[16], 0);
      end

      // RST opcode at address 9
      do_reset();
      prog[9] = W_RST;
      run = 1'b1;
      cycles(24);
      run = 1'b0;
      wait_idle("C2_idle");
      check("C2_fetch_count_ok", f_addr.size() >= 11, 1);
      if (f_addr.size() >= 11) begin
         check("C2_fetch9", f_addr[9], 9);
         check("C2_after_rst", f_addr[10], 0);
      end
      prog[9] = {8'h0A, 8'h09};

      // Fetch timeout: no ack for 15 cycles
      do_reset();
      imem_lat = 100;
      run = 1'b1;
      cycles(15);
      check("D1_still_fetching", imem_req, 1);
      check("D1_no_err_yet", err, 0);
      cycles(1);
      check("D1_err", err, 1);
      check("D1_busy", busy, 0);
      check("D1_req_low", imem_req, 0);
      cycles(5);
      check("D1_err_sticky", err, 1);
      check("D1_stays_stopped", busy, 0);
      run = 1'b0;

      // Ack on the 15th cycle for both fetch and data wait: no error
      do_reset();
      imem_lat = 14;
      dmem_lat = 14;
      prog[0] = W_ST;
      run = 1'b1;
      cycles(34);
      run = 1'b0;
      wait_idle("D2_idle");
      check("D2_no_err", err, 0);
      check("D2_dmem_cycles", d_cycles, 15);
      check("D2_pc", imem_addr, 2);
      imem_lat = 0;
      dmem_lat = 0;
      prog[0] = {8'h0A, 8'h00};

      // halt raised during MEMWAIT
      do_reset();
      prog[0] = W_LD;
      dmem_lat = 3;
      run = 1'b1;
      for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
      check("E_in_memwait", dmem_req, 1);
      halt = 1'b1;
      wait_idle("E_idle");
      cycles(5);
      check("E_pc", imem_addr, 1);
      check("E_fetches", f_addr.size(), 1);
      check("E_valids", v_addr.size(), 1);
      check("E_dmem_cycles", d_cycles, 4);
      check("E_no_req", imem_req, 0);
      halt = 1'b0;
      run = 1'b0;
      prog[0] = {8'h0A, 8'h00};

      // rst pulsed mid-MEMWAIT
      do_reset();
      prog[3] = W_LD;
      dmem_lat = 100;
      run = 1'b1;
      for (int i = 0; i < 30 && !dmem_req; i++) @(negedge clk);
      check("F_in_memwait", dmem_req, 1);
      cycles(2);
      #2 rst = 1'b1;
      #1;
      check("F_dmem_req_async", dmem_req, 0);
      check("F_busy_async", busy, 0);
      check("F_pc_async", imem_addr, 0);
      check("F_instr_async", instr, 16'h0000);
      check("F_valid_async", instr_valid, 0);
      check("F_imem_req_async", imem_req, 0);
      check("F_err_async", err, 0);
      run = 1'b0;
      cycles(2);
      rst = 1'b0;
      clear_logs();
      cycles(3);
      check("F_stays_idle", busy, 0);
      run = 1'b1;
      cycles(3);
      run = 1'b0;
      check("F_restart_fetch", f_addr.size() >= 1, 1);
      if (f_addr.size() >= 1) check("F_restart_addr", f_addr[0], 0);
      wait_idle("F_idle");
      dmem_lat = 0;

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "watchdog");
   end

endmodule
